id_ex_ctrl: RTL

Instruction-decode-to-execute control stage of the core. It decodes a 32-bit RV32I instruction into the `ex_alu_op` and `alu_funct` pair consumed by the EX-stage ALU control decoder, plus immediate and control flags. The decoded result is registered into a single ID/EX pipeline slot with valid/ready handshaking, flush, and load-use bubble insertion.

---
 rtl/id_ex_ctrl_if.sv | 52 +++++
 rtl/id_ex_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_ctrl_if.sv
// Bus between the ID stage, the ID/EX control slot and the EX stage.
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1; valid must not depend on ready, and the producer keeps its
// payload stable while valid=1 and ready=0.
interface id_ex_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    // ID side
    logic             id_valid;
    logic             id_ready;
    logic [31:0]      id_inst;
    logic [XLEN-1:0]  id_pc;
    logic             flush;
    // EX side
    logic             ex_ready;
    logic             ex_valid;
    logic [1:0]       ex_alu_op;
    logic [3:0]       ex_alu_funct;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic [XLEN-1:0]  ex_imm;
    logic             ex_src_imm;
    logic             ex_src_pc;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic             ex_reg_write;
    logic             ex_branch;
    logic             ex_jump;
    logic             ex_illegal;
    logic [XLEN-1:0]  ex_pc;
    logic [CNT_W-1:0] stall_cnt;

    // Environment view: drives ID/EX inputs, observes the slot.
    modport master (
        output id_valid, id_inst, id_pc, flush, ex_ready,
        input  id_ready, ex_valid, ex_alu_op, ex_alu_funct, ex_rs1, ex_rs2,
               ex_rd, ex_imm, ex_src_imm, ex_src_pc, ex_mem_read,
               ex_mem_write, ex_reg_write, ex_branch, ex_jump, ex_illegal,
               ex_pc, stall_cnt
    );

    // Control-stage view.
    modport slave (
        input  id_valid, id_inst, id_pc, flush, ex_ready,
        output id_ready, ex_valid, ex_alu_op, ex_alu_funct, ex_rs1, ex_rs2,
               ex_rd, ex_imm, ex_src_imm, ex_src_pc, ex_mem_read,
               ex_mem_write, ex_reg_write, ex_branch, ex_jump, ex_illegal,
               ex_pc, stall_cnt
    );
endinterface

// File: rtl/id_ex_ctrl.sv
// RV32I decode into a single registered ID/EX slot with valid/ready
// handshake, redirect flush and load-use bubble insertion.
module id_ex_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    id_ex_ctrl_if.slave      bus
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] ALU_OP_ADD = 2'b00;
    localparam logic [1:0] ALU_OP_SUB = 2'b01;
    localparam logic [1:0] ALU_OP_R   = 2'b10;
    localparam logic [1:0] ALU_OP_I   = 2'b11;

    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign inst   = bus.id_inst;
    assign opcode = inst[6:0];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    logic [1:0]  d_alu_op;
    logic [31:0] d_imm;
    logic        d_src_imm, d_src_pc, d_mem_read, d_mem_write;
    logic        d_reg_write, d_branch, d_jump, d_illegal;
    logic        d_rs1_used, d_rs2_used, d_rd_zero, d_rs1_zero;
    logic [4:0]  d_rs1, d_rs2, d_rd;

    // Combinational opcode decode into control flags and the selected immediate.
    always_comb begin
        d_alu_op    = ALU_OP_ADD;
        d_imm       = 32'b0;
        d_src_imm   = 1'b0;
        d_src_pc    = 1'b0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        d_reg_write = 1'b0;
        d_branch    = 1'b0;
        d_jump      = 1'b0;
        d_illegal   = 1'b0;
        d_rs1_used  = 1'b0;
        d_rs2_used  = 1'b0;
        d_rd_zero   = 1'b0;
        d_rs1_zero  = 1'b0;
        unique case (opcode)
            OP_R: begin
                d_alu_op    = ALU_OP_R;
                d_reg_write = 1'b1;
                d_rs1_used  = 1'b1;
                d_rs2_used  = 1'b1;
            end
            OP_IMM: begin
                d_alu_op    = ALU_OP_I;
                d_imm       = imm_i;
                d_src_imm   = 1'b1;
                d_reg_write = 1'b1;
                d_rs1_used  = 1'b1;
            end
            OP_LOAD: begin
                d_imm       = imm_i;
                d_src_imm   = 1'b1;
                d_mem_read  = 1'b1;
                d_reg_write = 1'b1;
                d_rs1_used  = 1'b1;
            end
            OP_STORE: begin
                d_imm       = imm_s;
                d_src_imm   = 1'b1;
                d_mem_write = 1'b1;
                d_rs1_used  = 1'b1;
                d_rs2_used  = 1'b1;
                d_rd_zero   = 1'b1;
            end
            OP_BRANCH: begin
                d_alu_op    = ALU_OP_SUB;
                d_imm       = imm_b;
                d_branch    = 1'b1;
                d_rs1_used  = 1'b1;
                d_rs2_used  = 1'b1;
                d_rd_zero   = 1'b1;
            end
            OP_LUI: begin
                d_imm       = imm_u;
                d_src_imm   = 1'b1;
                d_reg_write = 1'b1;
                d_rs1_zero  = 1'b1;
            end
            OP_AUIPC: begin
                // Operand A is the PC, so the rs1 field never reads the RF.
                d_imm       = imm_u;
                d_src_imm   = 1'b1;
                d_src_pc    = 1'b1;
                d_reg_write = 1'b1;
            end
            OP_JAL: begin
                d_imm       = imm_j;
                d_src_pc    = 1'b1;
                d_jump      = 1'b1;
                d_reg_write = 1'b1;
                d_rs1_zero  = 1'b1;
            end
            OP_JALR: begin
                d_imm       = imm_i;
                d_src_imm   = 1'b1;
                d_jump      = 1'b1;
                d_reg_write = 1'b1;
                d_rs1_used  = 1'b1;
            end
            default: begin
                d_illegal   = 1'b1;
            end
        endcase
    end

    assign d_rs1 = d_rs1_zero ? 5'd0 : inst[19:15];
    assign d_rs2 = d_rs2_used ? inst[24:20] : 5'd0;
    assign d_rd  = d_rd_zero  ? 5'd0 : inst[11:7];

    // Load-use: the load in the slot produces rd only after EX/MEM, so a
    // dependent instruction must wait one bubble behind it.
    logic hazard;
    assign hazard = bus.ex_valid & bus.ex_mem_read & (bus.ex_rd != 5'd0) & bus.id_valid &
                    ((d_rs1_used & (d_rs1 == bus.ex_rd)) |
                     (d_rs2_used & (d_rs2 == bus.ex_rd)));

    assign bus.id_ready = rst_n & ~bus.flush & ~hazard & (~bus.ex_valid | bus.ex_ready);

    // Bubble counter: one count per stalled edge, saturating, ignored under flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.stall_cnt <= '0;
        end else if (hazard && !bus.flush && (bus.stall_cnt != {CNT_W{1'b1}})) begin
            bus.stall_cnt <= bus.stall_cnt + 1'b1;
        end
    end

    // Slot update: reset, flush, hold under backpressure, load, else bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.ex_valid     <= 1'b0;
            bus.ex_alu_op    <= 2'b0;
            bus.ex_alu_funct <= 4'b0;
            bus.ex_rs1       <= 5'b0;
            bus.ex_rs2       <= 5'b0;
            bus.ex_rd        <= 5'b0;
            bus.ex_imm       <= '0;
            bus.ex_src_imm   <= 1'b0;
            bus.ex_src_pc    <= 1'b0;
            bus.ex_mem_read  <= 1'b0;
            bus.ex_mem_write <= 1'b0;
            bus.ex_reg_write <= 1'b0;
            bus.ex_branch    <= 1'b0;
            bus.ex_jump      <= 1'b0;
            bus.ex_illegal   <= 1'b0;
            bus.ex_pc        <= '0;
        end else if (bus.flush) begin
            bus.ex_valid <= 1'b0;
        end else if (bus.ex_valid && !bus.ex_ready) begin
            bus.ex_valid <= 1'b1;
        end else if (bus.id_valid && bus.id_ready) begin
            bus.ex_valid     <= 1'b1;
            bus.ex_alu_op    <= d_alu_op;
            bus.ex_alu_funct <= {inst[30], inst[14:12]};
            bus.ex_rs1       <= d_rs1;
            bus.ex_rs2       <= d_rs2;
            bus.ex_rd        <= d_rd;
            bus.ex_imm       <= XLEN'($signed(d_imm));
            bus.ex_src_imm   <= d_src_imm;
            bus.ex_src_pc    <= d_src_pc;
            bus.ex_mem_read  <= d_mem_read;
            bus.ex_mem_write <= d_mem_write;
            bus.ex_reg_write <= d_reg_write;
            bus.ex_branch    <= d_branch;
            bus.ex_jump      <= d_jump;
            bus.ex_illegal   <= d_illegal;
            bus.ex_pc        <= bus.id_pc;
        end else begin
            bus.ex_valid <= 1'b0;
        end
    end
endmodule
